glyph_row_serializer: RTL and testbench

- Requesting side of the character-ROM read interface: drives digit code, row offset and read strobe, captures the returned 8-bit glyph row and serializes it to one pixel per clock.
- Sits between the VGA timing logic and the ROM controller.
- On each line start it walks a string of NUM_CHARS digits for one glyph scanline and emits a gap-free pixel stream per character.

---
 rtl/glyph_row_serializer.sv | 144 ++++++++++++++
 tb/tb_glyph_row_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_row_serializer.sv
// Glyph row serializer: fetches one glyph scanline per digit from the character ROM and streams it MSB-first.
// Optional macro CHAR_GAP_EN inserts a single blank pixel between characters.
module glyph_row_serializer #(
  parameter int NUM_CHARS = 4,
  parameter int ROW_W     = 4,
  parameter int NUM_W     = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       lineStart,
  input  logic [ROW_W-1:0]           rowIdx,
  input  logic [NUM_CHARS*NUM_W-1:0] digitVec,
  input  logic [7:0]                 romByte,
  output logic [NUM_W-1:0]           reqNum,
  output logic [ROW_W-1:0]           reqOffset,
  output logic                       reqEnable,
  output logic                       pixelOut,
  output logic                       pixelValid,
  output logic                       busy,
  output logic                       lineDone
);

  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t                     state;
  logic [NUM_CHARS*NUM_W-1:0] digitReg;
  logic [ROW_W-1:0]           rowReg;
  logic [IDX_W-1:0]           charIdx;
  logic [IDX_W-1:0]           nextIdx;
  logic [NUM_W-1:0]           nextDigit;
  logic [7:0]                 shiftReg;
  logic [2:0]                 bitCnt;

  // Handshake: reqEnable is a single-cycle strobe raised only after reqNum/reqOffset
  // have been stable for a full cycle; the ROM side latches on its rising edge and
  // romByte is consumed one cycle later. pixelValid qualifies pixelOut with no
  // back-pressure: every valid cycle is one pixel.
  assign nextIdx   = charIdx + 1'b1;
  assign nextDigit = digitReg[nextIdx*NUM_W +: NUM_W];
  assign pixelOut  = pixelValid & shiftReg[7];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      digitReg   <= '0;
      rowReg     <= '0;
      charIdx    <= '0;
      shiftReg   <= 8'h00;
      bitCnt     <= 3'd0;
      reqNum     <= '0;
      reqOffset  <= '0;
      reqEnable  <= 1'b0;
      pixelValid <= 1'b0;
      busy       <= 1'b0;
      lineDone   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lineStart) begin
            digitReg  <= digitVec;
            rowReg    <= rowIdx;
            charIdx   <= '0;
            reqNum    <= digitVec[NUM_W-1:0];
            reqOffset <= rowIdx;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // Blank glyphs skip the ROM entirely.
          if (reqNum[NUM_W-1]) begin
            state <= LOAD;
          end else begin
            reqEnable <= 1'b1;
            state     <= STROBE;
          end
        end
        STROBE: begin
          reqEnable <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          shiftReg   <= reqNum[NUM_W-1] ? 8'h00 : romByte;
          bitCnt     <= 3'd0;
          pixelValid <= 1'b1;
          state      <= SHIFT;
        end
        SHIFT: begin
          shiftReg <= {shiftReg[6:0], 1'b0};
          bitCnt   <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            if (charIdx == LAST_IDX) begin
              pixelValid <= 1'b0;
              lineDone   <= 1'b1;
              state      <= DONE;
            end else begin
`ifdef CHAR_GAP_EN
              // Shift register is all zeros after eight shifts, so GAP emits a 0 pixel.
              state <= GAP;
`else
              pixelValid <= 1'b0;
              charIdx    <= nextIdx;
              reqNum     <= nextDigit;
              reqOffset  <= rowReg;
              state      <= SETUP;
`endif
            end
          end
        end
        GAP: begin
          pixelValid <= 1'b0;
          charIdx    <= nextIdx;
          reqNum     <= nextDigit;
          reqOffset  <= rowReg;
          state      <= SETUP;
        end
        DONE: begin
          lineDone <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          reqEnable  <= 1'b0;
          pixelValid <= 1'b0;
          lineDone   <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_row_serializer.sv
// Bench for glyph_row_serializer: reference model builds the expected pixel stream,
// ROM request list and line timing from digit codes; CHAR_GAP_EN follows the DUT build.
module tb_glyph_row_serializer;

  localparam int N   = 4;
  localparam int NW  = 3;
  localparam int RW  = 4;
  localparam int DW  = N * NW;
  localparam int RQW = NW + RW;
  localparam int BUDGET = 12 * N + 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          lineStart = 1'b0;
  logic [RW-1:0] rowIdx = '0;
  logic [DW-1:0] digitVec = '0;
  logic [7:0]    romByte = 8'h00;
  logic [NW-1:0] reqNum;
  logic [RW-1:0] reqOffset;
  logic          reqEnable;
  logic          pixelOut;
  logic          pixelValid;
  logic          busy;
  logic          lineDone;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0]     exp_q[$];
  logic [0:0]     obs_q[$];
  logic [RQW-1:0] exp_req_q[$];
  logic [RQW-1:0] obs_req_q[$];
  int exp_done, exp_first;
  int obs_done_cyc, obs_first, obs_done_cnt, obs_busy_bad;

  glyph_row_serializer #(.NUM_CHARS(N), .ROW_W(RW), .NUM_W(NW)) dut (
    .clock(clock), .reset(reset), .lineStart(lineStart), .rowIdx(rowIdx),
    .digitVec(digitVec), .romByte(romByte), .reqNum(reqNum), .reqOffset(reqOffset),
    .reqEnable(reqEnable), .pixelOut(pixelOut), .pixelValid(pixelValid),
    .busy(busy), .lineDone(lineDone)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rom_fn(input logic [NW-1:0] num, input logic [RW-1:0] off);
    logic [NW+RW+1:0] t;
    t = {num, off, 2'b01};
    return t[7:0];
  endfunction

  // ROM controller model: registers the glyph row on the read strobe.
  always @(posedge clock) begin
    if (reqEnable) romByte <= rom_fn(reqNum, reqOffset);
  end

  // Expected stream: 8 pixels per char (zeros when blank), a strobe per non-blank char,
  // 3 overhead cycles per non-blank char, 2 per blank one, DONE one cycle after the last pixel.
  task automatic build_expected(input logic [DW-1:0] dv, input logic [RW-1:0] row);
    logic [NW-1:0] d;
    logic [7:0]    g;
    exp_q.delete();
    exp_req_q.delete();
    exp_done  = 1;
    exp_first = 0;
    for (int c = 0; c < N; c++) begin
      d = dv[c*NW +: NW];
      if (c == 0) exp_first = d[NW-1] ? 3 : 4;
      if (d[NW-1]) begin
        g = 8'h00;
        exp_done += 10;
      end else begin
        g = rom_fn(d, row);
        exp_req_q.push_back({d, row});
        exp_done += 11;
      end
      for (int b = 7; b >= 0; b--) exp_q.push_back(g[b]);
`ifdef CHAR_GAP_EN
      if (c != N - 1) begin
        exp_q.push_back(1'b0);
        exp_done += 1;
      end
`endif
    end
  endtask

  // Pulses lineStart (sampled at edge 0) and records one observation per cycle.
  // ignore_at > 0 pulses lineStart again in that cycle; scramble changes inputs after sampling.
  task automatic run_line(input logic [DW-1:0] dv, input logic [RW-1:0] row,
                          input int ignore_at, input bit scramble);
    logic prev_en;
    obs_q.delete();
    obs_req_q.delete();
    obs_done_cyc = -1;
    obs_first    = -1;
    obs_done_cnt = 0;
    obs_busy_bad = 0;
    digitVec  = dv;
    rowIdx    = row;
    lineStart = 1'b1;
    @(posedge clock); #1;
    lineStart = 1'b0;
    if (scramble) begin
      digitVec = DW'($urandom);
      rowIdx   = RW'($urandom);
    end
    prev_en = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (reqEnable && !prev_en) obs_req_q.push_back({reqNum, reqOffset});
      prev_en = reqEnable;
      if (pixelValid) begin
        if (obs_first < 0) obs_first = cyc;
        obs_q.push_back(pixelOut);
      end
      if (lineDone) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) obs_done_cyc = cyc;
      end
      if (((obs_done_cyc < 0) || (cyc == obs_done_cyc)) !== busy) obs_busy_bad++;
      if (cyc == ignore_at) lineStart = 1'b1;
      @(posedge clock); #1;
      lineStart = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({reqEnable, pixelValid, pixelOut, busy, lineDone, reqNum, reqOffset} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all 0",
               {reqEnable, pixelValid, pixelOut, busy, lineDone, reqNum, reqOffset});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({reqEnable, pixelValid, pixelOut, busy, lineDone, reqNum, reqOffset} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs cycle %0d: got %b required all 0", i,
                 {reqEnable, pixelValid, pixelOut, busy, lineDone, reqNum, reqOffset});
      end
    end
  endtask

  task automatic test_lines();
    logic [DW-1:0] dv_t[4];
    int            ign_t[4];
    bit            scr_t[4];
    int            bad;
    dv_t[0] = {3'd3, 3'd2, 3'd1, 3'd0}; ign_t[0] = 0;  scr_t[0] = 1'b0;
    dv_t[1] = {3'd3, 3'd2, 3'd4, 3'd0}; ign_t[1] = 0;  scr_t[1] = 1'b0;
    dv_t[2] = {3'd3, 3'd2, 3'd1, 3'd0}; ign_t[2] = 10; scr_t[2] = 1'b1;
    dv_t[3] = {3'd3, 3'd2, 3'd1, 3'd0}; ign_t[3] = -1; scr_t[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      build_expected(dv_t[t], 4'd5);
      run_line(dv_t[t], 4'd5, (ign_t[t] < 0) ? exp_done : ign_t[t], scr_t[t]);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0 || obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL line%0d_pixels: got %0d pixels with %0d wrong, required %0d pixels",
                 t, obs_q.size(), bad, exp_q.size());
      end
      n_checks++;
      if (obs_req_q != exp_req_q) begin
        n_fail++;
        $display("FAIL line%0d_strobes: got %p required %p", t, obs_req_q, exp_req_q);
      end
      n_checks++;
      if (obs_done_cyc != exp_done || obs_done_cnt != 1) begin
        n_fail++;
        $display("FAIL line%0d_done: got cycle %0d count %0d, required cycle %0d count 1",
                 t, obs_done_cyc, obs_done_cnt, exp_done);
      end
      n_checks++;
      if (obs_first != exp_first) begin
        n_fail++;
        $display("FAIL line%0d_first_pixel: got cycle %0d required %0d", t, obs_first, exp_first);
      end
      n_checks++;
      if (obs_busy_bad != 0) begin
        n_fail++;
        $display("FAIL line%0d_busy: got %0d wrong cycles required 0", t, obs_busy_bad);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] dv;
    logic [RW-1:0] row;
    int            bad;
    for (int t = 0; t < 8; t++) begin
      dv  = DW'($urandom);
      row = RW'($urandom_range(0, (1 << RW) - 1));
      build_expected(dv, row);
      run_line(dv, row, 0, $urandom_range(0, 1) == 1);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0 || obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_pixels dv=%h: got %0d pixels with %0d wrong, required %0d",
                 t, dv, obs_q.size(), bad, exp_q.size());
      end
      n_checks++;
      if (obs_req_q != exp_req_q) begin
        n_fail++;
        $display("FAIL rand%0d_strobes: got %p required %p", t, obs_req_q, exp_req_q);
      end
      n_checks++;
      if (obs_done_cyc != exp_done || obs_done_cnt != 1 || obs_busy_bad != 0) begin
        n_fail++;
        $display("FAIL rand%0d_timing: got done %0d x%0d busy_bad %0d, required done %0d x1 busy_bad 0",
                 t, obs_done_cyc, obs_done_cnt, obs_busy_bad, exp_done);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [DW-1:0] dv;
    logic [RW-1:0] row;
    bit            seen_done;
    int            bad;
    for (int c = 0; c < N; c++) dv[c*NW +: NW] = NW'($urandom_range(0, 3));
    row       = RW'($urandom);
    digitVec  = dv;
    rowIdx    = row;
    lineStart = 1'b1;
    @(posedge clock); #1;
    lineStart = 1'b0;
    // Cycle 29 lies inside the third character's pixel run in both builds.
    repeat (28) @(posedge clock);
    #1;
    n_checks++;
    if (pixelValid !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_shifting: got pixelValid %b required 1", pixelValid);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({reqEnable, pixelValid, pixelOut, busy, lineDone} !== 5'b0) begin
      n_fail++;
      $display("FAIL midline_async_reset: got %b required 00000",
               {reqEnable, pixelValid, pixelOut, busy, lineDone});
    end
    seen_done = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lineDone || busy || pixelValid) seen_done = 1'b1;
      @(posedge clock); #1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midline_no_done: got activity after reset, required none");
    end
    dv  = DW'($urandom);
    row = RW'($urandom);
    build_expected(dv, row);
    run_line(dv, row, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0 || obs_q.size() != exp_q.size() || obs_req_q != exp_req_q) begin
      n_fail++;
      $display("FAIL after_reset_line: got %0d pixels %0d wrong strobes %p, required %0d pixels strobes %p",
               obs_q.size(), bad, obs_req_q, exp_q.size(), exp_req_q);
    end
    n_checks++;
    if (obs_done_cyc != exp_done || obs_done_cnt != 1 || obs_first != exp_first) begin
      n_fail++;
      $display("FAIL after_reset_timing: got done %0d x%0d first %0d, required done %0d x1 first %0d",
               obs_done_cyc, obs_done_cnt, obs_first, exp_done, exp_first);
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_random();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
